// File: rtl/nes_controller_reader_if.sv
// rtl/nes_controller_reader_if.sv - NES pad reader bus: tick/poll inputs, pad lines, button byte outputs
`timescale 1ns/1ps
interface nes_controller_reader_if;
    logic       tick;
    logic       start;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] buttons;
    logic       valid;
    logic       busy;

    modport master (
        output tick, start, nes_data,
        input  nes_latch, nes_pulse, buttons, valid, busy
    );

    modport slave (
        input  tick, start, nes_data,
        output nes_latch, nes_pulse, buttons, valid, busy
    );
endinterface

// File: rtl/nes_controller_reader.sv
// rtl/nes_controller_reader.sv - tick-paced NES pad LATCH/PULSE driver and 8-bit button shifter
// Optional NES_FRAME_FILTER_EN: publish a frame only when it matches the previous frame.
`timescale 1ns/1ps
module nes_controller_reader #(
    parameter int LATCH_TICKS = 2,
    parameter int CNT_W       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    nes_controller_reader_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_READ, S_PULSE, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_buttons;
    logic             r_latch;
    logic             r_pulse;
    logic             r_valid;
    logic             r_busy;
    logic             w_latch_last;
    logic             w_accept;

    assign w_latch_last = (r_cnt == CNT_W'(LATCH_TICKS - 1));

`ifdef NES_FRAME_FILTER_EN
    logic [7:0] r_prev;
    assign w_accept = (r_shift == r_prev);
`else
    assign w_accept = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_LATCH;
            S_LATCH: if (bus.tick && w_latch_last) w_next = S_READ;
            S_READ:  if (bus.tick) w_next = (r_idx == 3'd7) ? S_DONE : S_PULSE;
            S_PULSE: if (bus.tick) w_next = S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pad lines and busy are registered from the next state so they align with the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
            r_buttons <= 8'h00;
            r_latch   <= 1'b0;
            r_pulse   <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
`ifdef NES_FRAME_FILTER_EN
            r_prev    <= 8'h00;
`endif
        end else begin
            r_latch <= (w_next == S_LATCH);
            r_pulse <= (w_next == S_PULSE);
            r_busy  <= (w_next != S_IDLE);
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) r_cnt <= '0;
                S_LATCH: begin
                    if (bus.tick && w_latch_last) r_idx <= 3'd0;
                    else if (bus.tick)            r_cnt <= r_cnt + 1'b1;
                end
                S_READ:  if (bus.tick) r_shift[r_idx] <= ~bus.nes_data;
                S_PULSE: if (bus.tick) r_idx <= r_idx + 3'd1;
                S_DONE: begin
                    if (w_accept) begin
                        r_buttons <= r_shift;
                        r_valid   <= 1'b1;
                    end
`ifdef NES_FRAME_FILTER_EN
                    r_prev <= r_shift;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.nes_latch = r_latch;
    assign bus.nes_pulse = r_pulse;
    assign bus.buttons   = r_buttons;
    assign bus.valid     = r_valid;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_nes_controller_reader.sv
// tb/tb_nes_controller_reader.sv - self-checking bench for nes_controller_reader with a behavioural pad model
`timescale 1ns/1ps
module tb_nes_controller_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nes_controller_reader_if bus_if();

    nes_controller_reader #(.LATCH_TICKS(2), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int total = 0;
    int bad = 0;
    int tick_period = 4;

    logic [7:0] pad_bits = 8'h00;
    logic [2:0] pad_idx = 3'd0;
    logic       prev_pulse = 1'b0;
    int cyc = 0, busy_ticks = 0, latch_ticks = 0, pulse_ticks = 0, pulse_rises = 0;
    int valid_cnt = 0, last_tick_cyc = 0, valid_cyc = 0;
    logic [7:0] model_buttons = 8'h00;
    logic [7:0] model_prev = 8'h00;

    // Pad: LATCH reloads bit A, each PULSE rising edge advances to the next button.
    assign bus_if.nes_data = ~pad_bits[pad_idx];

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_pulse <= bus_if.nes_pulse;
        if (bus_if.nes_latch)                          pad_idx <= 3'd0;
        else if (bus_if.nes_pulse && !prev_pulse)      pad_idx <= pad_idx + 3'd1;
        if (bus_if.nes_pulse && !prev_pulse)           pulse_rises <= pulse_rises + 1;
        if (bus_if.tick) begin
            if (bus_if.busy) begin
                busy_ticks    <= busy_ticks + 1;
                last_tick_cyc <= cyc;
            end
            if (bus_if.nes_latch) latch_ticks <= latch_ticks + 1;
            if (bus_if.nes_pulse) pulse_ticks <= pulse_ticks + 1;
        end
        if (bus_if.valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
    end

    initial begin
        int phase;
        phase = 0;
        bus_if.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_period <= 1) begin
                bus_if.tick = 1'b1;
            end else begin
                bus_if.tick = (phase == 0);
                phase = (phase + 1 >= tick_period) ? 0 : phase + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_latch",   {31'd0, bus_if.nes_latch}, 32'd0);
        chk("rst_pulse",   {31'd0, bus_if.nes_pulse}, 32'd0);
        chk("rst_buttons", {24'd0, bus_if.buttons},   32'd0);
        chk("rst_valid",   {31'd0, bus_if.valid},     32'd0);
        chk("rst_busy",    {31'd0, bus_if.busy},      32'd0);
    endtask

    task automatic pulse_start();
        #1 bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        model_buttons = 8'h00;
        model_prev    = 8'h00;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // mode 1 adds stray start pulses at PULSE #3 and on the DONE cycle.
    task automatic run_frame(input logic [7:0] pressed, input int mode);
        int  b_busy, b_latch, b_pulse, b_rises, b_valid;
        bit  exp_valid, seen, done;
        pad_bits = pressed;
`ifdef NES_FRAME_FILTER_EN
        exp_valid = (pressed == model_prev);
`else
        exp_valid = 1'b1;
`endif
        model_prev = pressed;
        if (exp_valid) model_buttons = pressed;
        @(posedge clk);
        b_busy = busy_ticks; b_latch = latch_ticks; b_pulse = pulse_ticks;
        b_rises = pulse_rises; b_valid = valid_cnt;
        pulse_start();
        if (mode == 1) begin
            for (int i = 0; i < 200 && (pulse_rises - b_rises) < 3; i++) @(posedge clk);
            pulse_start();
            for (int i = 0; i < 200 && (busy_ticks - b_busy) < 17; i++) @(posedge clk);
            pulse_start();
        end
        seen = (mode == 1);
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (bus_if.busy) seen = 1'b1;
            else if (seen)   done = 1'b1;
        end
        repeat (4) @(negedge clk);
        #1;
        chk("frame_end",   {31'd0, done}, 32'd1);
        chk("valid_count", valid_cnt - b_valid, {31'd0, exp_valid});
        chk("buttons",     {24'd0, bus_if.buttons}, {24'd0, model_buttons});
        chk("latch_ticks", latch_ticks - b_latch, 32'd2);
        chk("pulse_highs", pulse_rises - b_rises, 32'd7);
        chk("pulse_ticks", pulse_ticks - b_pulse, 32'd7);
        chk("idle_busy",   {31'd0, bus_if.busy}, 32'd0);
        if (tick_period > 1) begin
            chk("frame_ticks", busy_ticks - b_busy, 32'd17);
            if (exp_valid) chk("valid_delay", valid_cyc - last_tick_cyc, 32'd2);
        end
    endtask

    initial begin
        int b_valid, b_rises;
        logic [7:0] last;
        logic [7:0] pick;
        bus_if.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        reset = 1'b0;

        tick_period = 4;
        run_frame(8'h09, 0);
        run_frame(8'h00, 0);
        run_frame(8'hFF, 0);
        run_frame(8'h09, 1);

        pad_bits = 8'h09;
        @(posedge clk);
        b_valid = valid_cnt;
        b_rises = pulse_rises;
        pulse_start();
        for (int i = 0; i < 200 && (pulse_rises - b_rises) < 4; i++) @(posedge clk);
        chk("abort_point", pulse_rises - b_rises, 32'd4);
        #1 reset = 1'b1;
        #1;
        chk_reset_outputs();
        model_buttons = 8'h00;
        model_prev    = 8'h00;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("abort_no_valid", valid_cnt - b_valid, 32'd0);
        run_frame(8'h09, 0);

        do_reset();
        run_frame(8'h09, 0);
        run_frame(8'h81, 0);
        run_frame(8'h81, 0);

        last = 8'h81;
        for (int n = 0; n < 8; n++) begin
            tick_period = $urandom_range(1, 4);
            pick = $urandom_range(0, 1) ? last : 8'($urandom);
            run_frame(pick, 0);
            last = pick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
